// File: rtl/nts_api_router.sv
// Routes one external register access to one of NUM_SLAVES register banks through a base/stop address map.
// Slaves may acknowledge with variable latency. Unmapped addresses and ack timeouts complete with an error response.
module nts_api_router #(
    parameter int                                NUM_SLAVES       = 6,
    parameter int                                ADDR_WIDTH       = 12,
    parameter int                                SLAVE_ADDR_WIDTH = 8,
    parameter int                                DATA_WIDTH       = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] MAP_BASE = {12'h0F0, 12'h0C0, 12'h080, 12'h020, 12'h010, 12'h000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] MAP_STOP = {12'h3FF, 12'h0FF, 12'h0BF, 12'h02F, 12'h01F, 12'h00F},
    parameter int                                TIMEOUT          = 15,
    parameter logic [DATA_WIDTH-1:0]             ERROR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                             i_clk,
    input  logic                             i_areset,
    output logic                             o_busy,
    input  logic                             i_ext_cs,
    input  logic                             i_ext_we,
    input  logic [ADDR_WIDTH-1:0]            i_ext_address,
    input  logic [DATA_WIDTH-1:0]            i_ext_write_data,
    output logic [DATA_WIDTH-1:0]            o_ext_read_data,
    output logic                             o_ext_read_data_valid,
    output logic                             o_ext_error,
    output logic                             o_ext_dropped,
    output logic [NUM_SLAVES-1:0]            o_int_cs,
    output logic                             o_int_we,
    output logic [SLAVE_ADDR_WIDTH-1:0]      o_int_address,
    output logic [DATA_WIDTH-1:0]            o_int_write_data,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_int_read_data,
    input  logic [NUM_SLAVES-1:0]            i_int_ack
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t                        r_state;
    logic                          r_we;
    logic [ADDR_WIDTH-1:0]         r_addr;
    logic [DATA_WIDTH-1:0]         r_wdata;
    logic [NUM_SLAVES-1:0]         r_sel;
    logic [CNT_W-1:0]              r_cnt;
    logic [NUM_SLAVES-1:0]         r_int_cs;
    logic                          r_int_we;
    logic [SLAVE_ADDR_WIDTH-1:0]   r_int_addr;
    logic [DATA_WIDTH-1:0]         r_int_wdata;
    logic [DATA_WIDTH-1:0]         r_rdata;
    logic                          r_valid;
    logic                          r_error;
    logic                          r_dropped;

    logic [NUM_SLAVES-1:0]         w_sel;
    logic [ADDR_WIDTH-1:0]         w_off;
    logic                          w_hit;
    logic                          w_ovf;
    logic                          w_ack;
    logic [DATA_WIDTH-1:0]         w_rdata;

    // Scan downward so the lowest matching index overwrites any higher one.
    always_comb begin
        w_sel = '0;
        w_off = '0;
        w_hit = 1'b0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (r_addr >= MAP_BASE[k*ADDR_WIDTH +: ADDR_WIDTH] &&
                r_addr <= MAP_STOP[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_hit    = 1'b1;
                w_sel    = '0;
                w_sel[k] = 1'b1;
                w_off    = r_addr - MAP_BASE[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign w_ovf = (w_off >> SLAVE_ADDR_WIDTH) != '0;
    assign w_ack = |(i_int_ack & r_sel);

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (r_sel[k]) w_rdata = w_rdata | i_int_read_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_int_cs    <= '0;
            r_int_we    <= 1'b0;
            r_int_addr  <= '0;
            r_int_wdata <= '0;
            r_rdata     <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_dropped <= i_ext_cs && (r_state != S_IDLE);
            r_int_cs  <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_rdata   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (i_ext_cs) begin
                        r_we    <= i_ext_we;
                        r_addr  <= i_ext_address;
                        r_wdata <= i_ext_write_data;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_hit && !w_ovf) begin
                        r_sel       <= w_sel;
                        r_int_cs    <= w_sel;
                        r_int_we    <= r_we;
                        r_int_addr  <= w_off[SLAVE_ADDR_WIDTH-1:0];
                        r_int_wdata <= r_wdata;
                        r_cnt       <= '0;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_valid <= 1'b1;
                        r_error <= 1'b1;
                        r_rdata <= r_we ? '0 : ERROR_DATA;
                        r_state <= S_RESPOND;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (w_ack || (r_state == S_WAIT && r_cnt == CNT_W'(TIMEOUT))) begin
                        r_valid     <= 1'b1;
                        r_error     <= !w_ack;
                        r_rdata     <= r_we ? '0 : (w_ack ? w_rdata : ERROR_DATA);
                        r_sel       <= '0;
                        r_int_we    <= 1'b0;
                        r_int_addr  <= '0;
                        r_int_wdata <= '0;
                        r_state     <= S_RESPOND;
                    end else if (r_state == S_ISSUE) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy                = (r_state != S_IDLE);
    assign o_ext_read_data       = r_rdata;
    assign o_ext_read_data_valid = r_valid;
    assign o_ext_error           = r_error;
    assign o_ext_dropped         = r_dropped;
    assign o_int_cs              = r_int_cs;
    assign o_int_we              = r_int_we;
    assign o_int_address         = r_int_addr;
    assign o_int_write_data      = r_int_wdata;

endmodule

// File: tb/tb_nts_api_router.sv
// Bench for nts_api_router: directed scenarios plus randomized transactions against a table-driven decode/timing model.
// A per-cycle driver plays the host and the slaves, recording what the router did for each transaction.
module tb_nts_api_router;

    localparam int NS = 6, AW = 12, SAW = 8, DW = 32, TO = 15;
    localparam logic [NS*AW-1:0] BASE = {12'h0F0, 12'h0C0, 12'h080, 12'h020, 12'h010, 12'h000};
    localparam logic [NS*AW-1:0] STOP = {12'h3FF, 12'h0FF, 12'h0BF, 12'h02F, 12'h01F, 12'h00F};
    localparam int MB [NS] = '{'h000, 'h010, 'h020, 'h080, 'h0C0, 'h0F0};
    localparam int MS [NS] = '{'h00F, 'h01F, 'h02F, 'h0BF, 'h0FF, 'h3FF};
    localparam logic [DW-1:0] EDATA = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              areset, cs, we, busy, valid, err, dropped, int_we;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata, rdata, int_wdata;
    logic [NS-1:0]     int_cs, ack;
    logic [SAW-1:0]    int_addr;
    logic [NS*DW-1:0]  rd_vec;

    int n_cmp = 0, n_bad = 0;

    // Per-transaction observations, cycle numbers relative to the cs cycle.
    int            obs_issue_cyc, obs_issue_cnt, obs_vcyc, obs_vcnt, obs_drop_cyc, obs_drop_cnt;
    int            obs_busy_first, obs_busy_last, obs_busy_n;
    logic [NS-1:0] obs_cs;
    logic          obs_we, obs_err;
    logic [SAW-1:0] obs_iaddr;
    logic [DW-1:0] obs_iwdata, obs_data;
    bit            obs_data_bad, obs_rst_zero;

    always #5 clk = ~clk;

    nts_api_router #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .SLAVE_ADDR_WIDTH(SAW), .DATA_WIDTH(DW),
        .MAP_BASE(BASE), .MAP_STOP(STOP), .TIMEOUT(TO), .ERROR_DATA(EDATA)
    ) dut (
        .i_clk(clk), .i_areset(areset), .o_busy(busy),
        .i_ext_cs(cs), .i_ext_we(we), .i_ext_address(addr), .i_ext_write_data(wdata),
        .o_ext_read_data(rdata), .o_ext_read_data_valid(valid), .o_ext_error(err),
        .o_ext_dropped(dropped), .o_int_cs(int_cs), .o_int_we(int_we),
        .o_int_address(int_addr), .o_int_write_data(int_wdata),
        .i_int_read_data(rd_vec), .i_int_ack(ack)
    );

    task automatic load_slaves();
        for (int s = 0; s < NS; s++) rd_vec[s*DW +: DW] = $urandom;
    endtask

    // ack_d: ack delay after issue (-1 none); late_ack/k2/kr: absolute cycles (-1 none).
    task automatic run_txn(input logic t_we, input logic [AW-1:0] t_addr, input logic [DW-1:0] t_wdata,
                           input int ack_d, input int late_ack, input int k2, input int kr,
                           input bit noise, input int ncyc);
        obs_issue_cyc = -1; obs_issue_cnt = 0; obs_vcyc = -1; obs_vcnt = 0;
        obs_drop_cyc = -1; obs_drop_cnt = 0; obs_busy_first = -1; obs_busy_last = -1; obs_busy_n = 0;
        obs_cs = '0; obs_we = 1'b0; obs_err = 1'b0; obs_iaddr = '0; obs_iwdata = '0; obs_data = '0;
        obs_data_bad = 1'b0; obs_rst_zero = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if (|int_cs) begin
                    obs_issue_cnt++;
                    if (obs_issue_cyc < 0) begin
                        obs_issue_cyc = k; obs_cs = int_cs; obs_we = int_we;
                        obs_iaddr = int_addr; obs_iwdata = int_wdata;
                    end
                end
                if (valid) begin
                    obs_vcnt++;
                    if (obs_vcyc < 0) begin obs_vcyc = k; obs_data = rdata; obs_err = err; end
                end else if (rdata !== '0) obs_data_bad = 1'b1;
                if (dropped) begin obs_drop_cnt++; obs_drop_cyc = k; end
                if (busy) begin
                    obs_busy_n++; obs_busy_last = k;
                    if (obs_busy_first < 0) obs_busy_first = k;
                end
                if (k == kr + 1)
                    obs_rst_zero = ({busy, valid, err, dropped, int_cs, int_we, int_addr, int_wdata, rdata} == '0);
            end
            cs = (k == 0) || (k == k2);
            areset = (k == kr);
            if (k == 0) begin
                we = t_we; addr = t_addr; wdata = t_wdata;
            end else if (k == k2) begin
                we = 1'($urandom); addr = AW'($urandom); wdata = $urandom;
            end
            ack = noise ? (NS'($urandom) & ~obs_cs) : '0;
            if (obs_issue_cyc >= 0 && ack_d >= 0 && k == obs_issue_cyc + ack_d) ack = ack | obs_cs;
            if (obs_issue_cyc >= 0 && k == late_ack) ack = ack | obs_cs;
        end
        @(negedge clk);
        cs = 1'b0; areset = 1'b0; ack = '0;
    endtask

    // Decode from the plain map table: first matching slave, error if unmapped or offset too wide.
    function automatic void model_decode(input logic [AW-1:0] a, output int sel, output logic [SAW-1:0] off,
                                         output bit e);
        int o;
        sel = -1; off = '0; e = 1'b1;
        for (int s = 0; s < NS; s++) begin
            if (sel < 0 && int'(a) >= MB[s] && int'(a) <= MS[s]) sel = s;
        end
        if (sel >= 0) begin
            o = int'(a) - MB[sel];
            if (o < 256) begin e = 1'b0; off = o[SAW-1:0]; end
        end
    endfunction

    task automatic test_reset();
        areset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0; ack = '0; load_slaves();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, valid, err, dropped, int_cs, int_we, int_addr, int_wdata, rdata} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got busy=%b valid=%b cs=%b rdata=%h, want all 0", busy, valid, int_cs, rdata);
        end
        areset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_same_cycle();
        load_slaves(); rd_vec[1*DW +: DW] = 32'h1234_5678;
        run_txn(1'b0, 12'h015, $urandom, 0, -1, -1, -1, 1'b0, 10);
        n_cmp++; if (obs_cs !== 6'b000010) begin n_bad++; $display("FAIL rd_int_cs: got %b want 000010", obs_cs); end
        n_cmp++; if (obs_issue_cyc != 2 || obs_iaddr !== 8'h05) begin n_bad++; $display("FAIL rd_issue: got cyc %0d addr %h want 2 05", obs_issue_cyc, obs_iaddr); end
        n_cmp++; if (obs_vcyc != 3 || obs_vcnt != 1) begin n_bad++; $display("FAIL rd_valid: got cyc %0d n %0d want 3 1", obs_vcyc, obs_vcnt); end
        n_cmp++; if (obs_data !== 32'h1234_5678 || obs_err !== 1'b0) begin n_bad++; $display("FAIL rd_data: got %h err %b want 12345678 0", obs_data, obs_err); end
        n_cmp++; if (obs_busy_first != 1 || obs_busy_last != 3 || obs_busy_n != 3) begin n_bad++; $display("FAIL rd_busy: got %0d..%0d n %0d want 1..3 n 3", obs_busy_first, obs_busy_last, obs_busy_n); end
    endtask

    task automatic test_write_delayed();
        load_slaves();
        run_txn(1'b1, 12'h085, 32'hCAFE_F00D, 4, -1, -1, -1, 1'b0, 12);
        n_cmp++; if (obs_cs !== 6'b001000 || obs_we !== 1'b1 || obs_iaddr !== 8'h05 || obs_iwdata !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL wr_issue: got cs %b we %b addr %h wd %h want 001000 1 05 cafef00d", obs_cs, obs_we, obs_iaddr, obs_iwdata); end
        n_cmp++; if (obs_vcyc != 7 || obs_data !== '0 || obs_err !== 1'b0) begin n_bad++; $display("FAIL wr_resp: got cyc %0d data %h err %b want 7 0 0", obs_vcyc, obs_data, obs_err); end
        n_cmp++; if (obs_data_bad) begin n_bad++; $display("FAIL wr_data_idle: got nonzero read data while valid low, want 0"); end
    endtask

    task automatic test_decode_boundaries();
        load_slaves();
        run_txn(1'b0, 12'h050, $urandom, 0, -1, -1, -1, 1'b0, 8);
        n_cmp++; if (obs_issue_cnt != 0 || obs_vcyc != 2 || obs_err !== 1'b1 || obs_data !== EDATA) begin
            n_bad++; $display("FAIL unmapped: got issues %0d cyc %0d err %b data %h want 0 2 1 deadbeef", obs_issue_cnt, obs_vcyc, obs_err, obs_data); end
        run_txn(1'b0, 12'h300, $urandom, 0, -1, -1, -1, 1'b0, 8);
        n_cmp++; if (obs_issue_cnt != 0 || obs_vcyc != 2 || obs_err !== 1'b1) begin
            n_bad++; $display("FAIL offset_ovf: got issues %0d cyc %0d err %b want 0 2 1", obs_issue_cnt, obs_vcyc, obs_err); end
        run_txn(1'b0, 12'h0F5, $urandom, 0, -1, -1, -1, 1'b0, 8);
        n_cmp++; if (obs_cs !== 6'b010000 || obs_iaddr !== 8'h35 || obs_data !== rd_vec[4*DW +: DW]) begin
            n_bad++; $display("FAIL overlap_low_wins: got cs %b addr %h data %h want 010000 35 %h", obs_cs, obs_iaddr, obs_data, rd_vec[4*DW +: DW]); end
        run_txn(1'b0, 12'h1EF, $urandom, 1, -1, -1, -1, 1'b0, 8);
        n_cmp++; if (obs_cs !== 6'b100000 || obs_iaddr !== 8'hFF || obs_err !== 1'b0 || obs_vcyc != 4) begin
            n_bad++; $display("FAIL max_offset: got cs %b addr %h err %b cyc %0d want 100000 ff 0 4", obs_cs, obs_iaddr, obs_err, obs_vcyc); end
    endtask

    task automatic test_timeout();
        load_slaves();
        run_txn(1'b0, 12'h150, $urandom, -1, 25, -1, -1, 1'b0, 30);
        n_cmp++; if (obs_vcyc != 19 || obs_err !== 1'b1 || obs_data !== EDATA) begin
            n_bad++; $display("FAIL timeout: got cyc %0d err %b data %h want 19 1 deadbeef", obs_vcyc, obs_err, obs_data); end
        n_cmp++; if (obs_vcnt != 1 || obs_busy_last != 19) begin n_bad++; $display("FAIL late_ack: got valids %0d busy_last %0d want 1 19", obs_vcnt, obs_busy_last); end
        run_txn(1'b0, 12'h150, $urandom, TO + 1, -1, -1, -1, 1'b0, 24);
        n_cmp++; if (obs_vcyc != 19 || obs_err !== 1'b0 || obs_data !== rd_vec[5*DW +: DW]) begin
            n_bad++; $display("FAIL ack_at_limit: got cyc %0d err %b data %h want 19 0 %h", obs_vcyc, obs_err, obs_data, rd_vec[5*DW +: DW]); end
        run_txn(1'b1, 12'h150, $urandom, TO + 2, -1, -1, -1, 1'b0, 24);
        n_cmp++; if (obs_vcyc != 19 || obs_err !== 1'b1 || obs_data !== '0) begin
            n_bad++; $display("FAIL ack_past_limit: got cyc %0d err %b data %h want 19 1 0", obs_vcyc, obs_err, obs_data); end
    endtask

    task automatic test_dropped();
        load_slaves();
        run_txn(1'b0, 12'h005, $urandom, 0, -1, 1, -1, 1'b0, 10);
        n_cmp++; if (obs_drop_cyc != 2 || obs_drop_cnt != 1 || obs_vcnt != 1 || obs_issue_cnt != 1) begin
            n_bad++; $display("FAIL drop_decode: got drop %0d/%0d valids %0d issues %0d want 2/1 1 1", obs_drop_cyc, obs_drop_cnt, obs_vcnt, obs_issue_cnt); end
        run_txn(1'b0, 12'h005, $urandom, 0, -1, 3, -1, 1'b0, 10);
        n_cmp++; if (obs_drop_cyc != 4 || obs_drop_cnt != 1 || obs_vcnt != 1 || obs_busy_last != 3) begin
            n_bad++; $display("FAIL drop_respond: got drop %0d/%0d valids %0d busy_last %0d want 4/1 1 3", obs_drop_cyc, obs_drop_cnt, obs_vcnt, obs_busy_last); end
    endtask

    task automatic test_reset_mid();
        load_slaves();
        run_txn(1'b0, 12'h150, $urandom, -1, -1, -1, 6, 1'b0, 26);
        n_cmp++; if (!obs_rst_zero) begin n_bad++; $display("FAIL reset_mid_outputs: got nonzero outputs after reset, want all 0"); end
        n_cmp++; if (obs_vcnt != 0 || obs_issue_cnt != 1 || obs_busy_last != 6) begin
            n_bad++; $display("FAIL reset_mid_abort: got valids %0d issues %0d busy_last %0d want 0 1 6", obs_vcnt, obs_issue_cnt, obs_busy_last); end
        run_txn(1'b0, 12'h02A, $urandom, 0, -1, -1, -1, 1'b0, 8);
        n_cmp++; if (obs_vcyc != 3 || obs_err !== 1'b0 || obs_data !== rd_vec[2*DW +: DW] || obs_iaddr !== 8'h0A) begin
            n_bad++; $display("FAIL after_reset_read: got cyc %0d err %b data %h addr %h want 3 0 %h 0a", obs_vcyc, obs_err, obs_data, obs_iaddr, rd_vec[2*DW +: DW]); end
    endtask

    task automatic test_random();
        int sel, d, exp_v, s;
        logic [SAW-1:0] off;
        logic [AW-1:0]  a;
        logic [DW-1:0]  wd, exp_d;
        logic           w;
        bit             e, exp_e;
        for (int n = 0; n < 60; n++) begin
            load_slaves();
            case ($urandom_range(0, 9))
                7:       a = AW'($urandom_range('h030, 'h07F));
                8, 9:    a = AW'($urandom);
                default: begin s = $urandom_range(0, NS - 1); a = AW'(MB[s] + $urandom_range(0, MS[s] - MB[s])); end
            endcase
            w = 1'($urandom); wd = $urandom;
            d = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, TO + 3);
            model_decode(a, sel, off, e);
            if (e) begin exp_v = 2; exp_e = 1'b1; end
            else if (d >= 0 && d <= TO + 1) begin exp_v = 3 + d; exp_e = 1'b0; end
            else begin exp_v = 3 + TO + 1; exp_e = 1'b1; end
            exp_d = w ? '0 : (exp_e ? EDATA : rd_vec[sel*DW +: DW]);
            run_txn(w, a, wd, d, -1, -1, -1, 1'b1, exp_v + 3);
            n_cmp++; if (obs_vcyc != exp_v || obs_vcnt != 1 || obs_err !== exp_e || obs_data !== exp_d) begin
                n_bad++; $display("FAIL rand_resp a=%h we=%b d=%0d: got cyc %0d n %0d err %b data %h want %0d 1 %b %h",
                                  a, w, d, obs_vcyc, obs_vcnt, obs_err, obs_data, exp_v, exp_e, exp_d); end
            if (e) begin
                n_cmp++; if (obs_issue_cnt != 0) begin n_bad++; $display("FAIL rand_no_issue a=%h: got %0d issues want 0", a, obs_issue_cnt); end
            end else begin
                n_cmp++; if (obs_issue_cnt != 1 || obs_issue_cyc != 2 || obs_cs !== NS'(1 << sel) || obs_iaddr !== off ||
                             obs_we !== w || obs_iwdata !== wd) begin
                    n_bad++; $display("FAIL rand_issue a=%h: got n %0d cyc %0d cs %b addr %h we %b wd %h want 1 2 slave %0d %h %b %h",
                                      a, obs_issue_cnt, obs_issue_cyc, obs_cs, obs_iaddr, obs_we, obs_iwdata, sel, off, w, wd); end
            end
            n_cmp++; if (obs_busy_first != 1 || obs_busy_last != exp_v || obs_busy_n != exp_v || obs_data_bad) begin
                n_bad++; $display("FAIL rand_busy a=%h: got %0d..%0d n %0d databad %0b want 1..%0d", a, obs_busy_first, obs_busy_last, obs_busy_n, obs_data_bad, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_read_same_cycle();
        test_write_delayed();
        test_decode_boundaries();
        test_timeout();
        test_dropped();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
